// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the unified memory interface
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  localparam int WORD_BYTES  = 4;
  localparam int MAX_LATENCY = 15;
  // Wide enough to hold MAX_LATENCY.
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM, synchronous write, combinational read port
module mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // The caller registers read data on its access edge.
  assign rdata = mem[idx];

endmodule

// File: rtl/unified_mem_if.sv
// rtl/unified_mem_if.sv - unified I/D memory with fixed-latency ready handshake
module unified_mem_if
  import mips_mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mem_en;
  logic [31:0]      mem_rdata;

  // Upper address bits select nothing: the index wraps modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Next-state: accept outside WAIT, count down in WAIT, access on the last wait edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_en  = 1'b0;
    if (state_q == WAIT) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        // A reset on this edge must discard the pending write.
        mem_en  = !reset;
        state_d = DONE;
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
      end
    end else if (req) begin
      we_d    = we;
      idx_d   = addr[AW+1:2];
      wdata_d = wdata;
      if (addr[1:0] != 2'b00) begin
        state_d = ERR;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_W'(LATENCY);
      end
    end else begin
      state_d = IDLE;
    end
  end

  // State, counter, request latches and read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = (state_q == DONE) || (state_q == ERR);
  assign busy       = (state_q == WAIT);
  assign misaligned = (state_q == ERR);

endmodule

// File: tb/tb_unified_mem_if.sv
// tb/tb_unified_mem_if.sv - directed scoreboard bench for unified_mem_if
module tb_unified_mem_if;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misaligned;

  typedef struct packed {
    logic        mis;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [DEPTH];
  logic [31:0] rdata_model;
  int          n_assert;
  int          n_fail;

  unified_mem_if #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .busy       (busy),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT can accept; returns at the negedge after the accept edge.
  task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    if (a[1:0] != 2'b00) begin
      e.mis = 1'b1;
    end else begin
      e.mis = 1'b0;
      if (w) mem_model[a[7:2]] = d;
      else   rdata_model = mem_model[a[7:2]];
    end
    e.rdata = rdata_model;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Waits (bounded) for the ready pulse, then scores latency, busy length and outputs.
  task automatic finish_req(input string tag, input int exp_wait);
    int   n;
    int   busy_n;
    exp_t e;
    n      = 0;
    busy_n = 0;
    while (!ready && n < 40) begin
      if (busy) busy_n++;
      chk({tag, "_mis_idle"}, 32'(misaligned), 32'd0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_wait));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_wait));
    chk({tag, "_busy_at_ready"}, 32'(busy), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_misaligned"}, 32'(misaligned), 32'(e.mis));
      chk({tag, "_rdata"}, rdata, e.rdata);
    end else begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic idle(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mis"}, 32'(misaligned), 32'd0);
      chk({tag, "_rdata"}, rdata, rdata_model);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rdata_model = 32'h0;
    reset       = 1'b1;
    req         = 1'b0;
    we          = 1'b0;
    addr        = 32'h0;
    wdata       = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    idle("reset_idle", 5);

    // Write then back-to-back read accepted in the DONE cycle.
    start(1'b1, 32'h10, 32'hDEADBEEF);
    finish_req("wr10", LATENCY);
    start(1'b0, 32'h10, 32'h0);
    finish_req("rd10", LATENCY);

    // Misaligned read, rejected immediately; rdata holds.
    start(1'b0, 32'h13, 32'h0);
    finish_req("mis13", 0);
    start(1'b0, 32'h10, 32'h0);
    finish_req("rd10_again", LATENCY);

    // Upper address bits ignored: 0x100 aliases index 0.
    start(1'b1, 32'h100, 32'h12345678);
    finish_req("wr100", LATENCY);
    start(1'b0, 32'h0, 32'h0);
    finish_req("rd0_wrap", LATENCY);
    idle("after_wrap", 1);

    // Known value at 0x20, then a write aborted by reset in its first WAIT cycle.
    start(1'b1, 32'h20, 32'h0BADF00D);
    finish_req("wr20", LATENCY);
    @(negedge clk);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdata_model = 32'h0;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_busy_clr", 32'(busy), 32'd0);
    chk("abort_mis", 32'(misaligned), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    start(1'b0, 32'h20, 32'h0);
    finish_req("rd20_after_abort", LATENCY);

    // req toggled with other addresses during WAIT must be ignored.
    @(negedge clk);
    start(1'b0, 32'h10, 32'h0);
    for (int i = 0; i < LATENCY; i++) begin
      req   = (i < LATENCY - 1) ? ((i % 2) == 0) : 1'b0;
      we    = 1'b1;
      addr  = 32'h40 + 32'(4 * i);
      wdata = 32'hFFFF0000 + 32'(i);
      chk("toggle_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    req = 1'b0;
    finish_req("toggle_rd10", 0);
    idle("toggle_no_extra", 4);
    chk("toggle_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
